// File: rtl/id_ex_reg_pkg.sv
// Shared constants for the ID/EX pipeline register: ALU opcode bus width,
// opcode encodings and reset/logic-level constants.
package id_ex_reg_pkg;

    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_NOP = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'd6;

    localparam logic RST_ENABLE  = 1'b1;
    localparam logic ZERO_SIGNAL = 1'b0;
    localparam logic ONE_SIGNAL  = 1'b1;

endpackage

// File: rtl/id_ex_reg_if.sv
// Decode-to-execute handshake and payload bundle. The master side is the
// decode/execute environment, the slave side is the pipeline register.
interface id_ex_reg_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    import id_ex_reg_pkg::*;

    logic                  id_valid_i;
    logic                  id_ready_o;
    logic                  flush_i;
    logic                  branch_i, mem_read_i, mem_to_reg_i;
    logic                  mem_write_i, alu_src_i, reg_write_i;
    logic [ALU_OP_W-1:0]   alu_op_i;
    logic [DATA_W-1:0]     rs1_data_i, rs2_data_i, imm_i, pc_i;
    logic [REG_ADDR_W-1:0] rd_addr_i;
    logic                  ex_ready_i;

    logic                  ex_valid_o;
    logic                  branch_o, mem_read_o, mem_to_reg_o;
    logic                  mem_write_o, alu_src_o, reg_write_o;
    logic [ALU_OP_W-1:0]   alu_op_o;
    logic [DATA_W-1:0]     rs1_data_o, rs2_data_o, imm_o, pc_o;
    logic [REG_ADDR_W-1:0] rd_addr_o;
    logic [CNT_W-1:0]      stall_cnt_o;

    modport master (
        output id_valid_i, flush_i, branch_i, mem_read_i, mem_to_reg_i,
               mem_write_i, alu_src_i, reg_write_i, alu_op_i, rs1_data_i,
               rs2_data_i, imm_i, pc_i, rd_addr_i, ex_ready_i,
        input  id_ready_o, ex_valid_o, branch_o, mem_read_o, mem_to_reg_o,
               mem_write_o, alu_src_o, reg_write_o, alu_op_o, rs1_data_o,
               rs2_data_o, imm_o, pc_o, rd_addr_o, stall_cnt_o
    );

    modport slave (
        input  id_valid_i, flush_i, branch_i, mem_read_i, mem_to_reg_i,
               mem_write_i, alu_src_i, reg_write_i, alu_op_i, rs1_data_i,
               rs2_data_i, imm_i, pc_i, rd_addr_i, ex_ready_i,
        output id_ready_o, ex_valid_o, branch_o, mem_read_o, mem_to_reg_o,
               mem_write_o, alu_src_o, reg_write_o, alu_op_o, rs1_data_o,
               rs2_data_o, imm_o, pc_o, rd_addr_o, stall_cnt_o
    );

endinterface

// File: rtl/id_ex_reg_sat_counter.sv
// Saturating up-counter for performance-debug events; sticks at all-ones
// and clears only on reset.
module sat_counter
    import id_ex_reg_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i == RST_ENABLE) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: valid/ready handshake with back-pressure hold,
// flush-to-bubble and a saturating stall-cycle counter.
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input logic         clk_i,
    input logic         rst_i,
    id_ex_reg_if.slave  bus
);

    logic                  ex_valid_q;
    logic [5:0]            ctrl_q;
    logic [ALU_OP_W-1:0]   alu_op_q;
    logic [DATA_W-1:0]     rs1_q, rs2_q, imm_q, pc_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  id_ready;
    logic                  accept;
    logic                  drain;
    logic                  stall;

    assign id_ready = (rst_i == RST_ENABLE) ? ZERO_SIGNAL
                    : (~ex_valid_q | bus.ex_ready_i | bus.flush_i);
    assign accept   = bus.id_valid_i & id_ready;
    assign drain    = ex_valid_q & bus.ex_ready_i;
    assign stall    = ex_valid_q & ~bus.ex_ready_i & ~bus.flush_i;

    // Bubbles clear only control and opcode; data fields are left alone since
    // nothing downstream can act on them without a valid control bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i == RST_ENABLE) begin
            ex_valid_q <= ZERO_SIGNAL;
            ctrl_q     <= '0;
            alu_op_q   <= ALU_NOP;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            rd_q       <= '0;
        end else if (bus.flush_i || (drain && !accept)) begin
            ex_valid_q <= ZERO_SIGNAL;
            ctrl_q     <= '0;
            alu_op_q   <= ALU_NOP;
        end else if (accept) begin
            ex_valid_q <= ONE_SIGNAL;
            ctrl_q     <= {bus.branch_i, bus.mem_read_i, bus.mem_to_reg_i,
                           bus.mem_write_i, bus.alu_src_i, bus.reg_write_i};
            alu_op_q   <= bus.alu_op_i;
            rs1_q      <= bus.rs1_data_i;
            rs2_q      <= bus.rs2_data_i;
            imm_q      <= bus.imm_i;
            pc_q       <= bus.pc_i;
            rd_q       <= bus.rd_addr_i;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc   (stall),
        .count (bus.stall_cnt_o)
    );

    assign bus.id_ready_o   = id_ready;
    assign bus.ex_valid_o   = ex_valid_q;
    assign {bus.branch_o, bus.mem_read_o, bus.mem_to_reg_o,
            bus.mem_write_o, bus.alu_src_o, bus.reg_write_o} = ctrl_q;
    assign bus.alu_op_o     = alu_op_q;
    assign bus.rs1_data_o   = rs1_q;
    assign bus.rs2_data_o   = rs2_q;
    assign bus.imm_o        = imm_q;
    assign bus.pc_o         = pc_q;
    assign bus.rd_addr_o    = rd_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed scenarios plus randomized traffic
// compared against a slot-level model of the pipeline register.
module tb_id_ex_reg;
    import id_ex_reg_pkg::*;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 16;
    localparam int SAT_W      = 4;

    typedef struct packed {
        logic                  branch, mem_read, mem_to_reg;
        logic                  mem_write, alu_src, reg_write;
        logic [ALU_OP_W-1:0]   alu_op;
        logic [DATA_W-1:0]     rs1, rs2, imm, pc;
        logic [REG_ADDR_W-1:0] rd;
    } entry_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    id_ex_reg_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) bus ();
    id_ex_reg_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CNT_W(SAT_W)) bus_sat ();

    id_ex_reg #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    id_ex_reg #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CNT_W(SAT_W)) dut_sat (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus_sat)
    );

    int     compared   = 0;
    int     mismatched = 0;
    bit     exp_valid;
    entry_t exp_e;
    int     exp_cnt;
    entry_t drv_e;

    function automatic entry_t observed();
        entry_t e;
        e = {bus.branch_o, bus.mem_read_o, bus.mem_to_reg_o, bus.mem_write_o,
             bus.alu_src_o, bus.reg_write_o, bus.alu_op_o, bus.rs1_data_o,
             bus.rs2_data_o, bus.imm_o, bus.pc_o, bus.rd_addr_o};
        return e;
    endfunction

    function automatic entry_t rand_entry();
        entry_t e;
        {e.branch, e.mem_read, e.mem_to_reg, e.mem_write, e.alu_src, e.reg_write} = 6'($urandom);
        e.alu_op = ALU_OP_W'($urandom);
        e.rs1    = $urandom;
        e.rs2    = $urandom;
        e.imm    = $urandom;
        e.pc     = $urandom;
        e.rd     = REG_ADDR_W'($urandom);
        return e;
    endfunction

    function automatic entry_t bubble_of(input entry_t e);
        entry_t b;
        b = e;
        {b.branch, b.mem_read, b.mem_to_reg, b.mem_write, b.alu_src, b.reg_write} = 6'b0;
        b.alu_op = ALU_NOP;
        return b;
    endfunction

    function automatic bit exp_ready();
        return !exp_valid || bus.ex_ready_i || bus.flush_i;
    endfunction

    task automatic drive(input entry_t e, input bit v, input bit exr, input bit fl);
        drv_e          = e;
        bus.id_valid_i = v;
        bus.ex_ready_i = exr;
        bus.flush_i    = fl;
        {bus.branch_i, bus.mem_read_i, bus.mem_to_reg_i, bus.mem_write_i,
         bus.alu_src_i, bus.reg_write_i, bus.alu_op_i, bus.rs1_data_i,
         bus.rs2_data_i, bus.imm_i, bus.pc_i, bus.rd_addr_i} = e;
    endtask

    task automatic model_reset();
        exp_valid = 1'b0;
        exp_e     = '0;
        exp_e.alu_op = ALU_NOP;
        exp_cnt   = 0;
    endtask

    // The slot holds at most one instruction; decide what it holds after the edge.
    task automatic model_edge();
        bit rdy;
        rdy = exp_ready();
        if (exp_valid && !bus.ex_ready_i && !bus.flush_i && exp_cnt < (1 << CNT_W) - 1)
            exp_cnt = exp_cnt + 1;
        if (bus.flush_i) begin
            exp_valid = 1'b0;
            exp_e     = bubble_of(exp_e);
        end else if (bus.id_valid_i && rdy) begin
            exp_valid = 1'b1;
            exp_e     = drv_e;
        end else if (exp_valid && bus.ex_ready_i) begin
            exp_valid = 1'b0;
            exp_e     = bubble_of(exp_e);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic check_state(input string tag);
        compared++;
        if ({bus.ex_valid_o, observed(), bus.stall_cnt_o} !== {exp_valid, exp_e, CNT_W'(exp_cnt)}) begin
            mismatched++;
            $display("[TB] FAIL %s state: got %h want %h", tag,
                     {bus.ex_valid_o, observed(), bus.stall_cnt_o},
                     {exp_valid, exp_e, CNT_W'(exp_cnt)});
        end
    endtask

    task automatic check_ready(input string tag);
        compared++;
        if (bus.id_ready_o !== exp_ready()) begin
            mismatched++;
            $display("[TB] FAIL %s id_ready: got %b want %b", tag, bus.id_ready_o, exp_ready());
        end
    endtask

    task automatic test_reset();
        drive('0, 1'b0, 1'b0, 1'b0);
        model_reset();
        #3;
        check_state("reset");
        compared++;
        if (bus.id_ready_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset id_ready: got %b want 0", bus.id_ready_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_ori();
        entry_t e;
        e = '0;
        e.alu_op = ALU_OR; e.alu_src = 1'b1; e.reg_write = 1'b1;
        e.rs1 = 32'h0000_1200; e.imm = 32'h0000_0034; e.rd = 5'd5;
        drive(e, 1'b1, 1'b1, 1'b0);
        #1 check_ready("ori");
        tick();
        check_state("ori load");
        compared++;
        if (observed() !== e || bus.ex_valid_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL ori fields: got %h want %h", observed(), e);
        end
        drive(e, 1'b0, 1'b1, 1'b0);
        tick();
        check_state("ori drain");
        compared++;
        if (bus.ex_valid_o !== 1'b0 || bus.reg_write_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL ori bubble: got valid=%b rw=%b want 0 0", bus.ex_valid_o, bus.reg_write_o);
        end
    endtask

    task automatic test_back_pressure();
        entry_t e1, e2;
        int base;
        e1 = rand_entry();
        e2 = rand_entry();
        drive(e1, 1'b1, 1'b1, 1'b0);
        tick();
        check_state("bp load");
        drive(e2, 1'b1, 1'b0, 1'b0);
        base = exp_cnt;
        for (int k = 1; k <= 3; k++) begin
            #1 check_ready("bp hold");
            tick();
            check_state("bp hold");
            compared++;
            if (bus.stall_cnt_o !== CNT_W'(base + k) || observed() !== e1) begin
                mismatched++;
                $display("[TB] FAIL bp count: got %0d want %0d", bus.stall_cnt_o, base + k);
            end
        end
        drive(e2, 1'b1, 1'b1, 1'b0);
        tick();
        check_state("bp release");
        compared++;
        if (observed() !== e2) begin
            mismatched++;
            $display("[TB] FAIL bp new entry: got %h want %h", observed(), e2);
        end
    endtask

    task automatic test_flush();
        entry_t e;
        e = rand_entry();
        e.mem_write = 1'b1;
        drive(e, 1'b1, 1'b0, 1'b1);
        #1 check_ready("flush");
        tick();
        check_state("flush");
        compared++;
        if (bus.ex_valid_o !== 1'b0 || bus.mem_write_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL flush kill: got valid=%b mw=%b want 0 0", bus.ex_valid_o, bus.mem_write_o);
        end
    endtask

    task automatic test_flush_during_hold();
        entry_t e;
        int base;
        e = rand_entry();
        drive(e, 1'b1, 1'b1, 1'b0);
        tick();
        drive(e, 1'b0, 1'b0, 1'b0);
        tick();
        check_state("hold before flush");
        base = exp_cnt;
        drive(e, 1'b0, 1'b0, 1'b1);
        tick();
        check_state("flush in hold");
        compared++;
        if (bus.stall_cnt_o !== CNT_W'(base) || bus.ex_valid_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL flush hold: got cnt=%0d valid=%b want %0d 0", bus.stall_cnt_o, bus.ex_valid_o, base);
        end
    endtask

    task automatic test_back_to_back();
        entry_t e;
        for (int k = 0; k < 8; k++) begin
            e = rand_entry();
            drive(e, 1'b1, 1'b1, 1'b0);
            tick();
            check_state("b2b");
            compared++;
            if (observed() !== e || bus.ex_valid_o !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL b2b entry %0d: got %h want %h", k, observed(), e);
            end
        end
        drive(e, 1'b0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_saturation();
        int want;
        bus_sat.id_valid_i = 1'b1;
        bus_sat.ex_ready_i = 1'b1;
        @(posedge clk_i); #1;
        bus_sat.id_valid_i = 1'b0;
        bus_sat.ex_ready_i = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk_i); #1;
            want = (k > 15) ? 15 : k;
            compared++;
            if (bus_sat.stall_cnt_o !== SAT_W'(want) || bus_sat.ex_valid_o !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL sat cycle %0d: got %0d want %0d", k, bus_sat.stall_cnt_o, want);
            end
        end
    endtask

    task automatic test_random();
        entry_t e;
        bit v, hold_inputs;
        e = rand_entry();
        v = 1'b0;
        for (int k = 0; k < 300; k++) begin
            hold_inputs = v && !exp_ready();
            if (!hold_inputs) begin
                v = ($urandom % 4) != 0;
                e = rand_entry();
            end
            drive(e, v, ($urandom % 3) != 0, ($urandom % 16) == 0);
            #1 check_ready("random");
            tick();
            check_state("random");
        end
    endtask

    task automatic test_async_reset();
        entry_t e;
        e = rand_entry();
        e.reg_write = 1'b1;
        drive(e, 1'b1, 1'b1, 1'b0);
        tick();
        drive(e, 1'b0, 1'b0, 1'b0);
        tick();
        check_state("pre reset");
        #2 rst_i = 1'b1;
        #1;
        compared++;
        if (bus.ex_valid_o !== 1'b0 || bus.reg_write_o !== 1'b0 || bus.stall_cnt_o !== '0 ||
            bus.alu_op_o !== ALU_NOP || bus.id_ready_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL async reset: got valid=%b rw=%b cnt=%0d op=%0d rdy=%b want 0 0 0 %0d 0",
                     bus.ex_valid_o, bus.reg_write_o, bus.stall_cnt_o, bus.alu_op_o, bus.id_ready_o, ALU_NOP);
        end
        model_reset();
        check_state("async reset");
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        bus_sat.id_valid_i = 1'b0; bus_sat.ex_ready_i = 1'b0; bus_sat.flush_i = 1'b0;
        {bus_sat.branch_i, bus_sat.mem_read_i, bus_sat.mem_to_reg_i, bus_sat.mem_write_i,
         bus_sat.alu_src_i, bus_sat.reg_write_i} = 6'b0;
        bus_sat.alu_op_i = ALU_ADD;
        bus_sat.rs1_data_i = '0; bus_sat.rs2_data_i = '0; bus_sat.imm_i = '0;
        bus_sat.pc_i = '0; bus_sat.rd_addr_i = '0;
        test_reset();
        test_ori();
        test_back_pressure();
        test_flush();
        test_flush_during_hold();
        test_back_to_back();
        test_saturation();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- Pipeline register between the decode stage (instruction fields, control decoder, regfile reads) and the execute stage.
- Captures decoded control signals, operands, immediate, destination register and PC under a valid/ready handshake.
- Supports back-pressure hold and flush-to-bubble.
- Provides a saturating stall-cycle counter for performance debug.

Parameters:
- DATA_W, 32, width of operands, immediate and PC.
- REG_ADDR_W, 5, width of the register address field.
- CNT_W, 16, width of the stall counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high (`RstEnable` = 1).
- id_valid_i  in  1  decode stage presents a valid instruction.
- id_ready_o  out  1  this register can accept this cycle.
- flush_i  in  1  kill the held and incoming instruction (branch redirect).
- branch_i, mem_read_i, mem_to_reg_i, mem_write_i, alu_src_i, reg_write_i  in  1 each  decoded control bits.
- alu_op_i  in  `ALUOpBus  ALU operation code.
- rs1_data_i, rs2_data_i  in  DATA_W  regfile read data.
- imm_i  in  DATA_W  sign-extended immediate.
- pc_i  in  DATA_W  instruction PC.
- rd_addr_i  in  REG_ADDR_W  destination register.
- ex_ready_i  in  1  execute stage consumes this cycle.
- ex_valid_o  out  1  held entry is valid.
- branch_o, mem_read_o, mem_to_reg_o, mem_write_o, alu_src_o, reg_write_o  out  1 each  registered control bits.
- alu_op_o  out  `ALUOpBus  registered ALU operation code.
- rs1_data_o, rs2_data_o, imm_o, pc_o  out  DATA_W  registered data.
- rd_addr_o  out  REG_ADDR_W  registered destination.
- stall_cnt_o  out  CNT_W  saturating count of back-pressured cycles.

Behaviour:
- Reset (async, while rst_i=1):
  - ex_valid_o=0; all control outputs 0; alu_op_o=`NOP.
  - Data outputs and rd_addr_o = 0; stall_cnt_o=0.
- id_ready_o (combinational) = ~ex_valid_o | ex_ready_i | flush_i. It is 0 during reset.
- Latency: exactly 1 cycle from accepted input to output.
- Events per rising edge, in priority order:
  1. flush_i=1:
     - ex_valid_o<=0; control outputs <= 0; alu_op_o <= `NOP.
     - Data and rd_addr_o hold their values.
     - An incoming instruction that cycle is dropped, even if id_valid_i=1.
  2. Accept (id_valid_i & id_ready_o): all outputs load their inputs; ex_valid_o<=1.
  3. Drain (ex_valid_o & ex_ready_i, no accept): becomes a bubble, same as flush.
  4. Hold (ex_valid_o & ~ex_ready_i): every output keeps its value.
  5. Otherwise: remains a bubble.
- Invariant: ex_valid_o=0 implies every control output is 0 and alu_op_o=`NOP. A bubble can never write a register or memory.
- Simultaneous drain and accept (ex_valid_o=1, ex_ready_i=1, id_valid_i=1): the new entry replaces the old back-to-back with no bubble. Sustained throughput is 1 instruction per cycle.
- Stall counter:
  - Increments when ex_valid_o=1 & ex_ready_i=0 & flush_i=0.
  - Saturates at 2^CNT_W-1; no wrap-around.
  - Cleared only by reset.
- Input-stability rule: upstream holds its inputs stable while id_valid_i=1 & id_ready_o=0. Verification asserts this; the block does not check it.

Decomposition:
- Shared define include holds `ALUOpBus`, `NOP`, `RstEnable`, `ZeroSignal`, `OneSignal`. No new typedefs.
- One natural sub-module: sat_counter (parameter CNT_W; ports inc, count). It is reused by other perf counters.
- The handshake/payload register stays inline.

Test Plan:
1. rst_i asserted mid-cycle with ex_valid_o=1 -> ex_valid_o, reg_write_o and stall_cnt_o go to 0 immediately without waiting for a clock edge; alu_op_o=`NOP.
2. ORI decode (alu_op_i=`OR, alu_src_i=1, reg_write_i=1, rs1_data_i=0x0000_1200, imm_i=0x0000_0034, rd_addr_i=5), ex_ready_i=1 -> next cycle outputs carry exactly those values with ex_valid_o=1. With id_valid_i=0 the following cycle, ex_valid_o=0 and reg_write_o=0.
3. Back-pressure: ex_ready_i=0 for 3 cycles with an entry held -> outputs unchanged, id_ready_o=0, stall_cnt_o counts 1,2,3. With ex_ready_i=1 and a new valid input, the new entry is loaded next cycle.
4. flush_i=1 with id_valid_i=1 and mem_write_i=1 -> next cycle ex_valid_o=0 and mem_write_o=0; id_ready_o=1 during the flush cycle.
5. flush_i=1 while held under ex_ready_i=0 -> entry killed; stall_cnt_o does not increment on the flush cycle.
6. CNT_W=4, ex_ready_i=0 for 20 cycles with an entry held -> stall_cnt_o reaches 15 and stays at 15.
